// File: rtl/stream_demux_n.sv
// stream_demux_n
//   1-to-NCH stream demultiplexer with a 2-entry FIFO per output channel.
//   Each accepted input word is routed to channel in_sel, or to every channel
//   when in_bcast=1. Words aimed at a non-existent channel (in_sel >= NCH) are
//   accepted, discarded and counted in a saturating error counter.
//   in_ready depends only on registered FIFO occupancy plus the current
//   mode/select, never on out_ready or in_valid.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    input word
//   in_sel     destination channel
//   in_bcast   1 = deliver the word to every channel (in_sel ignored)
//   in_valid   input word present
//   in_ready   block accepts the word this cycle
//   out_data   channel k head word at [k*WIDTH +: WIDTH]
//   out_valid  per-channel valid (FIFO not empty)
//   out_ready  per-channel consumer ready
//   err_cnt    saturating count of dropped out-of-range words
module stream_demux_n #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 4,
  parameter int ERRW  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SELW-1:0]      in_sel,
  input  logic                 in_bcast,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [ERRW-1:0]      err_cnt
);

  // Packed per-channel storage; head_q flattens directly onto out_data.
  logic [NCH-1:0][1:0]       cnt_q;
  logic [NCH-1:0][WIDTH-1:0] head_q;
  logic [NCH-1:0][WIDTH-1:0] tail_q;

  logic [NCH-1:0] sel_hit;   // one-hot decode of in_sel; all zero when out of range
  logic [NCH-1:0] full;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  logic           xfer;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    sel_hit   = '0;
    full      = '0;
    out_valid = '0;
    for (int k = 0; k < NCH; k++) begin
      sel_hit[k]   = (32'(in_sel) == $unsigned(k));
      full[k]      = (cnt_q[k] == 2'd2);
      out_valid[k] = (cnt_q[k] != 2'd0);
    end

    if (rst)
      in_ready = 1'b0;
    else if (in_bcast)
      in_ready = ~|full;
    else if (|sel_hit)
      in_ready = ~|(sel_hit & full);
    else
      in_ready = 1'b1;          // out-of-range word: always sink it

    xfer = in_valid & in_ready;
    push = '0;
    pop  = '0;
    for (int k = 0; k < NCH; k++) begin
      push[k] = xfer & (in_bcast | sel_hit[k]);
      pop[k]  = out_valid[k] & out_ready[k];
    end
  end

  assign out_data = head_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the FIFO storage is reset as well because out_data must read
      // zero after reset; with two entries per channel this is cheap.
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      err_cnt <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        // A push only reaches a channel with cnt < 2, so push&pop implies cnt==1.
        unique case ({push[k], pop[k]})
          2'b10: begin
            if (cnt_q[k] == 2'd0) begin
              head_q[k] <= in_data;
              cnt_q[k]  <= 2'd1;
            end else begin
              tail_q[k] <= in_data;
              cnt_q[k]  <= 2'd2;
            end
          end
          2'b01: begin
            head_q[k] <= tail_q[k];   // stale when emptying; hidden by out_valid=0
            cnt_q[k]  <= cnt_q[k] - 2'd1;
          end
          2'b11: head_q[k] <= in_data; // single entry leaves, new word becomes head
          default: ;
        endcase
      end

      if (xfer && !in_bcast && !(|sel_hit) && !(&err_cnt))
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_demux_n.sv
// tb_stream_demux_n
//   Self-checking bench for stream_demux_n (NCH=5, SELW=3, ERRW=2 so that a
//   non-power-of-two channel count, out-of-range selects and counter
//   saturation are all reachable). A queue-per-channel reference model is
//   stepped on every clock edge; directed scenarios check hand-derived
//   constants and a randomized phase checks against the model.
module tb_stream_demux_n;

  localparam int W = 8;
  localparam int N = 5;
  localparam int S = 3;
  localparam int E = 2;

  logic           clk;
  logic           rst;
  logic [W-1:0]   in_data;
  logic [S-1:0]   in_sel;
  logic           in_bcast;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready;
  logic [E-1:0]   err_cnt;

  int nvec  = 0;
  int nmiss = 0;

  // Reference model: one queue per channel plus an error count.
  logic [W-1:0] mq [N][$];
  int           merr = 0;

  stream_demux_n #(.WIDTH(W), .NCH(N), .SELW(S), .ERRW(E)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] dch(int k);
    return out_data[k*W +: W];
  endfunction

  function automatic logic m_ready();
    if (rst) return 1'b0;
    if (in_bcast) begin
      for (int k = 0; k < N; k++)
        if (mq[k].size() >= 2) return 1'b0;
      return 1'b1;
    end
    if (int'(in_sel) < N) return (mq[in_sel].size() < 2);
    return 1'b1;
  endfunction

  // Advance one edge and apply the same edge to the model; returns 1ns later.
  task automatic tick();
    logic acc;
    @(posedge clk);
    acc = in_valid && m_ready();
    if (rst) begin
      for (int k = 0; k < N; k++) mq[k].delete();
      merr = 0;
    end else begin
      for (int k = 0; k < N; k++)
        if (mq[k].size() != 0 && out_ready[k]) void'(mq[k].pop_front());
      if (acc) begin
        if (in_bcast)
          for (int k = 0; k < N; k++) mq[k].push_back(in_data);
        else if (int'(in_sel) < N)
          mq[in_sel].push_back(in_data);
        else if (merr < (1 << E) - 1)
          merr++;
      end
    end
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    in_bcast  = 1'b0;
    out_ready = '1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_sel = '0; in_bcast = 1'b0;
    in_data = 8'hEE; out_ready = '1;
    repeat (2) begin
      tick();
      nvec++; if (in_ready !== 1'b0) begin nmiss++; $display("FAIL reset_ready: got %b want 0", in_ready); end
      nvec++; if (out_valid !== '0) begin nmiss++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      nvec++; if (err_cnt !== '0) begin nmiss++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
      nvec++; if (out_data !== '0) begin nmiss++; $display("FAIL reset_data: got %h want 0", out_data); end
    end
    rst = 1'b0; in_valid = 1'b0;
    repeat (2) begin
      tick();
      nvec++; if (out_valid !== '0) begin nmiss++; $display("FAIL reset_release_valid: got %b want 0", out_valid); end
    end
  endtask

  task automatic test_unicast();
    out_ready = '1; in_bcast = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_sel = S'(k); in_data = W'(8'hA0 + k); #1;
      nvec++; if (in_ready !== 1'b1) begin nmiss++; $display("FAIL uni_ready ch%0d: got %b want 1", k, in_ready); end
      tick();
      nvec++; if (out_valid !== N'(1 << k)) begin nmiss++; $display("FAIL uni_valid ch%0d: got %b want %b", k, out_valid, N'(1 << k)); end
      nvec++; if (dch(k) !== W'(8'hA0 + k)) begin nmiss++; $display("FAIL uni_data ch%0d: got %h want %h", k, dch(k), W'(8'hA0 + k)); end
    end
    in_valid = 1'b0;
    tick();
    nvec++; if (out_valid !== '0) begin nmiss++; $display("FAIL uni_idle: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 5'b11011; in_bcast = 1'b0; in_sel = 3'd2; in_valid = 1'b1;
    in_data = 8'h11; #1;
    nvec++; if (in_ready !== 1'b1) begin nmiss++; $display("FAIL bp_ready0: got %b want 1", in_ready); end
    tick();
    in_data = 8'h22; #1;
    nvec++; if (in_ready !== 1'b1) begin nmiss++; $display("FAIL bp_ready1: got %b want 1", in_ready); end
    tick();
    in_data = 8'h33; #1;
    nvec++; if (in_ready !== 1'b0) begin nmiss++; $display("FAIL bp_full: got %b want 0", in_ready); end
    tick();
    nvec++; if (in_ready !== 1'b0) begin nmiss++; $display("FAIL bp_full_hold: got %b want 0", in_ready); end
    nvec++; if (dch(2) !== 8'h11 || !out_valid[2]) begin nmiss++; $display("FAIL bp_head: got %h/%b want 11/1", dch(2), out_valid[2]); end
    out_ready[2] = 1'b1; #1;
    nvec++; if (in_ready !== 1'b0) begin nmiss++; $display("FAIL bp_full_pop: got %b want 0", in_ready); end
    tick();
    nvec++; if (in_ready !== 1'b1) begin nmiss++; $display("FAIL bp_reopen: got %b want 1", in_ready); end
    nvec++; if (dch(2) !== 8'h22) begin nmiss++; $display("FAIL bp_second: got %h want 22", dch(2)); end
    tick();
    in_valid = 1'b0;
    nvec++; if (dch(2) !== 8'h33 || !out_valid[2]) begin nmiss++; $display("FAIL bp_third: got %h/%b want 33/1", dch(2), out_valid[2]); end
    tick();
    nvec++; if (out_valid[2] !== 1'b0) begin nmiss++; $display("FAIL bp_empty: got %b want 0", out_valid[2]); end
  endtask

  task automatic test_broadcast();
    out_ready = 5'b10101; in_bcast = 1'b0; in_valid = 1'b1;
    in_sel = 3'd1; in_data = 8'h61; tick();
    in_data = 8'h62; tick();
    in_sel = 3'd3; in_data = 8'h71; tick();
    in_bcast = 1'b1; in_sel = 3'd7; in_data = 8'h5A; #1;
    nvec++; if (in_ready !== 1'b0) begin nmiss++; $display("FAIL bc_stall: got %b want 0", in_ready); end
    tick();
    nvec++; if (in_ready !== 1'b0) begin nmiss++; $display("FAIL bc_stall2: got %b want 0", in_ready); end
    nvec++; if (out_valid !== 5'b01010) begin nmiss++; $display("FAIL bc_pre_valid: got %b want 01010", out_valid); end
    out_ready[1] = 1'b1; #1;
    nvec++; if (in_ready !== 1'b0) begin nmiss++; $display("FAIL bc_full_pop: got %b want 0", in_ready); end
    tick();
    nvec++; if (in_ready !== 1'b1) begin nmiss++; $display("FAIL bc_reopen: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0; in_bcast = 1'b0;
    nvec++; if (out_valid !== 5'b11111) begin nmiss++; $display("FAIL bc_valid: got %b want 11111", out_valid); end
    for (int k = 0; k < N; k++) begin
      nvec++;
      if (dch(k) !== ((k == 3) ? 8'h71 : 8'h5A)) begin
        nmiss++; $display("FAIL bc_data ch%0d: got %h want %h", k, dch(k), (k == 3) ? 8'h71 : 8'h5A);
      end
    end
    out_ready = '1;
    tick();
    nvec++; if (out_valid !== 5'b01000 || dch(3) !== 8'h5A) begin nmiss++; $display("FAIL bc_ch3_after: got %b/%h want 01000/5a", out_valid, dch(3)); end
    drain();
  endtask

  task automatic test_error();
    out_ready = '1; in_bcast = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_sel = S'(5 + i % 3); in_data = W'($urandom); #1;
      nvec++; if (in_ready !== 1'b1) begin nmiss++; $display("FAIL err_ready %0d: got %b want 1", i, in_ready); end
      tick();
      nvec++; if (err_cnt !== E'((i + 1 > 3) ? 3 : i + 1)) begin nmiss++; $display("FAIL err_cnt %0d: got %0d want %0d", i, err_cnt, (i + 1 > 3) ? 3 : i + 1); end
      nvec++; if (out_valid !== '0) begin nmiss++; $display("FAIL err_novalid %0d: got %b want 0", i, out_valid); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_isolation();
    out_ready = 5'b11110; in_bcast = 1'b0; in_valid = 1'b1;
    in_sel = 3'd0; in_data = 8'hC1; tick();
    in_data = 8'hC2; tick();
    in_sel = 3'd1;
    for (int i = 0; i < 8; i++) begin
      in_data = W'(8'h80 + i); #1;
      nvec++; if (in_ready !== 1'b1) begin nmiss++; $display("FAIL iso_ready %0d: got %b want 1", i, in_ready); end
      tick();
      nvec++; if (dch(1) !== W'(8'h80 + i) || !out_valid[1]) begin nmiss++; $display("FAIL iso_ch1 %0d: got %h/%b want %h/1", i, dch(1), out_valid[1], W'(8'h80 + i)); end
      nvec++; if (dch(0) !== 8'hC1 || !out_valid[0]) begin nmiss++; $display("FAIL iso_ch0 %0d: got %h/%b want c1/1", i, dch(0), out_valid[0]); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_midreset();
    // Channel 0 still holds two stalled words from the isolation scenario.
    rst = 1'b1; in_valid = 1'b1; in_sel = 3'd1; in_data = 8'hDD; #1;
    nvec++; if (in_ready !== 1'b0) begin nmiss++; $display("FAIL mid_ready: got %b want 0", in_ready); end
    tick();
    rst = 1'b0; in_valid = 1'b0;
    nvec++; if (out_valid !== '0 || out_data !== '0) begin nmiss++; $display("FAIL mid_clear: got %b/%h want 0/0", out_valid, out_data); end
    nvec++; if (err_cnt !== '0) begin nmiss++; $display("FAIL mid_err: got %0d want 0", err_cnt); end
    tick();
    nvec++; if (out_valid !== '0) begin nmiss++; $display("FAIL mid_after: got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    logic hold;
    hold = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!hold) begin
        in_valid = ($urandom_range(3) != 0);
        in_bcast = ($urandom_range(7) == 0);
        in_sel   = S'($urandom);
        in_data  = W'($urandom);
      end
      out_ready = N'($urandom);
      #1;
      nvec++; if (in_ready !== m_ready()) begin nmiss++; $display("FAIL rnd_ready c%0d: got %b want %b", c, in_ready, m_ready()); end
      hold = in_valid && !m_ready();
      tick();
      for (int k = 0; k < N; k++) begin
        nvec++;
        if (out_valid[k] !== (mq[k].size() != 0)) begin
          nmiss++; $display("FAIL rnd_valid c%0d ch%0d: got %b want %b", c, k, out_valid[k], mq[k].size() != 0);
        end else if (mq[k].size() != 0 && dch(k) !== mq[k][0]) begin
          nmiss++; $display("FAIL rnd_data c%0d ch%0d: got %h want %h", c, k, dch(k), mq[k][0]);
        end
      end
      nvec++; if (err_cnt !== E'(merr)) begin nmiss++; $display("FAIL rnd_err c%0d: got %0d want %0d", c, err_cnt, merr); end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bcast = 1'b0; in_sel = '0;
    in_data = '0; out_ready = '1;
    test_reset();
    test_unicast();
    test_backpressure();
    drain();
    test_broadcast();
    test_error();
    drain();
    test_isolation();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
